bit_comparator: RTL and testbench
=================================

Name: bit_comparator

Overview:
- Registered N-bit magnitude comparator. Compares operands a and b and produces one-hot less/equal/greater flags with a valid strobe.
- Used as a leaf datapath block wherever a registered three-way compare result is needed, e.g. threshold checks and sort/select stages.
- Compare logic is an MSB-first priority scan. The result is registered once.

Parameters:
- N, 4, operand width in bits (N >= 1).
- SIGNED, 0, 0 = unsigned magnitude compare; 1 = two's-complement compare.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears all state immediately, deassertion is synchronised by the integrator.
- in_valid  input  1  a/b are sampled on a rising clk edge when high.
- a  input  N  operand A.
- b  input  N  operand B.
- out_valid  output  1  high for exactly one cycle per accepted input; result flags are valid while high.
- less  output  1  registered result: a < b.
- equal  output  1  registered result: a == b.
- greater  output  1  registered result: a > b.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid, less, equal and greater are all 0, and remain 0 until the first accepted compare.
- Latency is 1 cycle. If in_valid = 1 at edge k, then after edge k out_valid = 1 and the flags reflect a/b sampled at edge k.
- If in_valid = 0 at an edge, out_valid goes to 0 and less/equal/greater hold their last values.
- Throughput is one compare per cycle. Back-to-back valid inputs produce back-to-back results. There is no backpressure.
- After the first accepted compare, exactly one of less/equal/greater is 1 (one-hot), always.
- Unsigned mode (SIGNED = 0):
  - Scan from bit N-1 down to 0; the first differing bit decides.
  - At that bit, a = 1 / b = 0 gives greater; a = 0 / b = 1 gives less.
  - No differing bit gives equal.
- Signed mode (SIGNED = 1):
  - If the MSBs differ, the operand with MSB = 1 is less.
  - Otherwise apply the unsigned scan to bits N-2..0.
  - For N = 1: 1 is less than 0.
- Inputs are sampled only on a valid edge. a/b changes between edges have no effect.
- If reset asserts mid-operation, any in-flight result is discarded and outputs go to 0 immediately. The first valid edge after release produces a fresh result with normal 1-cycle latency.
- The block contains no X-propagation guards. The integrator keeps a/b known whenever in_valid = 1.

Optional Feature:
- Macro: BIT_COMPARATOR_STATS_EN.
- When defined, the block adds:
  - Input stats_clr (1 bit). A synchronous clear that zeroes all counters on the next edge; clear takes priority over increment in the same cycle.
  - Outputs cnt_less, cnt_equal, cnt_greater, each 16 bits.
- Each counter increments by 1 on every edge where in_valid = 1 and the newly computed result matches its class.
- Counters saturate at 16'hFFFF (no wrap) and reset to 0 on rst_n low.
- When not defined, these ports and counters are absent. Core behaviour is identical in both builds.

Test Plan:
- Reset and idle:
  - Assert rst_n = 0 mid-cycle -> out_valid/less/equal/greater = 0 immediately, without waiting for a clk edge.
  - Release with in_valid = 0 -> outputs stay 0.
- Directed N = 4, SIGNED = 0, one vector per cycle with in_valid = 1; each result appears 1 cycle later with out_valid = 1:
  - a = 0000, b = 0000 -> equal.
  - a = 0001, b = 0010 -> less.
  - a = 1010, b = 0101 -> greater.
  - a = 1111, b = 1111 -> equal.
  - a = 1000, b = 1001 -> less.
  - a = 0111, b = 0011 -> greater.
- Hold behaviour: a = 1010, b = 0101 with in_valid = 1, then in_valid = 0 while a/b change to 0000/1111 -> out_valid drops to 0, greater stays 1, less/equal stay 0.
- Signed mode, N = 4, SIGNED = 1:
  - a = 1000 (-8), b = 0111 (+7) -> less.
  - a = 1111 (-1), b = 1110 (-2) -> greater.
  - Same a = 1000, b = 0111 with SIGNED = 0 -> greater.
- Reset mid-stream: issue a = 0001, b = 0010 with in_valid = 1, then assert rst_n before the result edge -> no out_valid pulse. After release, a = 0011, b = 0011 -> equal after 1 cycle.
- BIT_COMPARATOR_STATS_EN build:
  - Run the six directed vectors -> cnt_less = 2, cnt_equal = 2, cnt_greater = 2.
  - Assert stats_clr together with in_valid (a = 0000, b = 0001) -> all counters read 0 after the edge.
  - Preload to saturation via 65536 equal compares -> cnt_equal stays 16'hFFFF.

Source files
------------

// File: rtl/bit_comparator.sv
// Registered N-bit three-way magnitude comparator (unsigned or two's-complement).
// Optional per-class result counters are enabled with BIT_COMPARATOR_STATS_EN.
module bit_comparator #(
  parameter int unsigned N      = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic         less,
  output logic         equal,
  output logic         greater
`ifdef BIT_COMPARATOR_STATS_EN
  ,
  input  logic         stats_clr,
  output logic [15:0]  cnt_less,
  output logic [15:0]  cnt_equal,
  output logic [15:0]  cnt_greater
`endif
);

  localparam int unsigned CW = 16;

  logic found_c;
  logic lt_c;
  logic gt_c;
  logic eq_c;

  logic out_valid_d, out_valid_q;
  logic less_d, less_q;
  logic equal_d, equal_q;
  logic greater_d, greater_q;

  // MSB-first scan; in signed mode a set sign bit makes that operand the smaller one.
  always_comb begin
    found_c = 1'b0;
    lt_c    = 1'b0;
    gt_c    = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!found_c && (a[i] != b[i])) begin
        found_c = 1'b1;
        if ((SIGNED != 0) && (i == int'(N) - 1)) begin
          lt_c = a[i];
          gt_c = b[i];
        end else begin
          lt_c = b[i];
          gt_c = a[i];
        end
      end
    end
    eq_c = !found_c;
  end

  always_comb begin
    out_valid_d = in_valid;
    less_d      = less_q;
    equal_d     = equal_q;
    greater_d   = greater_q;
    if (in_valid) begin
      less_d    = lt_c;
      equal_d   = eq_c;
      greater_d = gt_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      less_q      <= 1'b0;
      equal_q     <= 1'b0;
      greater_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      less_q      <= less_d;
      equal_q     <= equal_d;
      greater_q   <= greater_d;
    end
  end

  assign out_valid = out_valid_q;
  assign less      = less_q;
  assign equal     = equal_q;
  assign greater   = greater_q;

`ifdef BIT_COMPARATOR_STATS_EN
  logic [CW-1:0] cnt_less_d, cnt_less_q;
  logic [CW-1:0] cnt_equal_d, cnt_equal_q;
  logic [CW-1:0] cnt_greater_d, cnt_greater_q;

  // Saturating counters; clear wins over a same-cycle increment.
  always_comb begin
    cnt_less_d    = cnt_less_q;
    cnt_equal_d   = cnt_equal_q;
    cnt_greater_d = cnt_greater_q;
    if (stats_clr) begin
      cnt_less_d    = '0;
      cnt_equal_d   = '0;
      cnt_greater_d = '0;
    end else if (in_valid) begin
      if (lt_c && (cnt_less_q != '1)) cnt_less_d = cnt_less_q + CW'(1);
      if (eq_c && (cnt_equal_q != '1)) cnt_equal_d = cnt_equal_q + CW'(1);
      if (gt_c && (cnt_greater_q != '1)) cnt_greater_d = cnt_greater_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_less_q    <= '0;
      cnt_equal_q   <= '0;
      cnt_greater_q <= '0;
    end else begin
      cnt_less_q    <= cnt_less_d;
      cnt_equal_q   <= cnt_equal_d;
      cnt_greater_q <= cnt_greater_d;
    end
  end

  assign cnt_less    = cnt_less_q;
  assign cnt_equal   = cnt_equal_q;
  assign cnt_greater = cnt_greater_q;
`endif

endmodule

// File: tb/tb_bit_comparator.sv
// Directed self-checking bench for bit_comparator: an unsigned and a signed
// instance share the same stimulus; flags are checked as {out_valid,less,equal,greater}.
module tb_bit_comparator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       u_ov, u_lt, u_eq, u_gt;
  logic       s_ov, s_lt, s_eq, s_gt;
  int         checks;
  int         errors;

`ifdef BIT_COMPARATOR_STATS_EN
  logic        stats_clr;
  logic [15:0] u_cl, u_ce, u_cg;
  logic [15:0] s_cl, s_ce, s_cg;
`endif

  bit_comparator #(.N(4), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(u_ov), .less(u_lt), .equal(u_eq), .greater(u_gt)
`ifdef BIT_COMPARATOR_STATS_EN
    , .stats_clr(stats_clr), .cnt_less(u_cl), .cnt_equal(u_ce), .cnt_greater(u_cg)
`endif
  );

  bit_comparator #(.N(4), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(s_ov), .less(s_lt), .equal(s_eq), .greater(s_gt)
`ifdef BIT_COMPARATOR_STATS_EN
    , .stats_clr(stats_clr), .cnt_less(s_cl), .cnt_equal(s_ce), .cnt_greater(s_cg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] R_ZERO = 4'b0000;
  localparam logic [3:0] R_LT   = 4'b1100;
  localparam logic [3:0] R_EQ   = 4'b1010;
  localparam logic [3:0] R_GT   = 4'b1001;
  localparam logic [3:0] H_LT   = 4'b0100;
  localparam logic [3:0] H_GT   = 4'b0001;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: apply inputs, let one rising edge pass, return at the next negedge.
  task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv);
    in_valid = v;
    a        = av;
    b        = bv;
    @(negedge clk);
  endtask

  task automatic both(input string tag, input logic [3:0] eu, input logic [3:0] es);
    chk({tag, "_u"}, {u_ov, u_lt, u_eq, u_gt}, eu);
    chk({tag, "_s"}, {s_ov, s_lt, s_eq, s_gt}, es);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
`ifdef BIT_COMPARATOR_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    both("reset", R_ZERO, R_ZERO);
    rst_n = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000);
    both("idle", R_ZERO, R_ZERO);

    // Directed vectors back-to-back
    drive(1'b1, 4'b0000, 4'b0000); both("v0000_0000", R_EQ, R_EQ);
    drive(1'b1, 4'b0001, 4'b0010); both("v0001_0010", R_LT, R_LT);
    drive(1'b1, 4'b1010, 4'b0101); both("v1010_0101", R_GT, R_LT);
    drive(1'b1, 4'b1111, 4'b1111); both("v1111_1111", R_EQ, R_EQ);
    drive(1'b1, 4'b1000, 4'b1001); both("v1000_1001", R_LT, R_LT);
    drive(1'b1, 4'b0111, 4'b0011); both("v0111_0011", R_GT, R_GT);
`ifdef BIT_COMPARATOR_STATS_EN
    chk16("cnt_less_u", u_cl, 16'd2);
    chk16("cnt_equal_u", u_ce, 16'd2);
    chk16("cnt_greater_u", u_cg, 16'd2);
    chk16("cnt_less_s", s_cl, 16'd3);
    chk16("cnt_equal_s", s_ce, 16'd2);
    chk16("cnt_greater_s", s_cg, 16'd1);
`endif

    // Hold: flags keep last result while out_valid drops
    drive(1'b1, 4'b1010, 4'b0101); both("hold_load", R_GT, R_LT);
    drive(1'b0, 4'b0000, 4'b1111); both("hold_idle", H_GT, H_LT);
    drive(1'b0, 4'b0011, 4'b0001); both("hold_idle2", H_GT, H_LT);

    // Signed boundary vectors
    drive(1'b1, 4'b1000, 4'b0111); both("sgn_m8_p7", R_GT, R_LT);
    drive(1'b1, 4'b1111, 4'b1110); both("sgn_m1_m2", R_GT, R_GT);
    drive(1'b1, 4'b0000, 4'b1111); both("sgn_0_m1", R_LT, R_GT);

`ifdef BIT_COMPARATOR_STATS_EN
    stats_clr = 1'b1;
    drive(1'b1, 4'b0000, 4'b0001);
    stats_clr = 1'b0;
    both("clr_cmp", R_LT, R_LT);
    chk16("clr_less", u_cl, 16'd0);
    chk16("clr_equal", u_ce, 16'd0);
    chk16("clr_greater", u_cg, 16'd0);
    repeat (65536) drive(1'b1, 4'b0101, 4'b0101);
    chk16("sat_equal", u_ce, 16'hFFFF);
    chk16("sat_less_untouched", u_cl, 16'd0);
    drive(1'b1, 4'b0000, 4'b0000);
    chk16("sat_equal_hold", u_ce, 16'hFFFF);
    drive(1'b1, 4'b0000, 4'b0001);
`endif

    // Establish a known non-zero output, then reset before the next result edge
    drive(1'b1, 4'b0000, 4'b0001); both("pre_rst", R_LT, R_LT);
    in_valid = 1'b1;
    a        = 4'b0001;
    b        = 4'b0010;
    #2;
    rst_n = 1'b0;
    #1;
    both("async_rst", R_ZERO, R_ZERO);
    @(negedge clk);
    both("rst_no_pulse", R_ZERO, R_ZERO);
`ifdef BIT_COMPARATOR_STATS_EN
    chk16("rst_cnt_equal", u_ce, 16'd0);
`endif
    in_valid = 1'b0;
    rst_n    = 1'b1;
    drive(1'b0, 4'b0001, 4'b0010); both("post_rst_idle", R_ZERO, R_ZERO);
    drive(1'b1, 4'b0011, 4'b0011); both("post_rst_eq", R_EQ, R_EQ);
    drive(1'b0, 4'b0000, 4'b0000); both("post_rst_drop", H_LT & 4'b0000 | 4'b0010, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
